// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the memory arbiter: FSM states, owner IDs,
// and memSize codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational owner select. On a tie, grant the requester that did not
// win last time; a constant last=fetch input gives fixed data priority.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic rr_last,
    output logic any_req,
    output logic owner
);

    always_comb begin
        any_req = if_req | d_req;
        owner   = OWN_FETCH;
        if (if_req && d_req) begin
            owner = ~rr_last;
        end else if (d_req) begin
            owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to single memory port arbiter, one transaction in flight.
// Define MEM_ARBITER_RR_EN for round-robin on ties; default is data priority.
//
//   state    | meaning
//   ST_IDLE  | no transaction; grant combinationally and latch request fields
//   ST_ISSUE | m_req held with latched fields until m_ready
//   ST_RESP  | waiting for m_rvalid or timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        if_stall,
    output logic        d_stall,
    output logic        err
);

    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [7:0]  cnt_q;
    logic        if_rvalid_q, d_rvalid_q, err_q;
    logic [31:0] if_rdata_q, d_rdata_q;

    logic any_req, pick, rr_last;
    logic done, timed_out, proto_err;

`ifdef MEM_ARBITER_RR_EN
    logic last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= OWN_FETCH;
        end else if (state_q == ST_IDLE && any_req) begin
            last_q <= pick;
        end
    end

    assign rr_last = last_q;
`else
    assign rr_last = OWN_FETCH;
`endif

    mem_arb_picker u_picker (
        .if_req  (if_req),
        .d_req   (d_req),
        .rr_last (rr_last),
        .any_req (any_req),
        .owner   (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        m_req     = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                proto_err = m_rvalid;
                if (any_req) begin
                    if_gnt  = (pick == OWN_FETCH);
                    d_gnt   = (pick == OWN_DATA);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_req = 1'b1;
                if (m_ready) begin
                    if (m_rvalid) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    proto_err = m_rvalid;
                end
            end
            ST_RESP: begin
                if (m_rvalid) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= OWN_FETCH;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && any_req) begin
                owner_q <= pick;
                if (pick == OWN_DATA) begin
                    we_q    <= d_we;
                    size_q  <= d_size;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else begin
                    we_q    <= 1'b0;
                    size_q  <= SIZE_WORD;
                    addr_q  <= if_addr;
                    wdata_q <= 32'd0;
                end
            end

            cnt_q <= (state_q == ST_RESP) ? cnt_q + 8'd1 : 8'd0;

            if_rvalid_q <= done && (owner_q == OWN_FETCH);
            d_rvalid_q  <= done && (owner_q == OWN_DATA);

            // A timed-out response returns zero data so the owner can unblock.
            if (done && owner_q == OWN_FETCH) begin
                if_rdata_q <= timed_out ? 32'd0 : m_rdata;
            end
            if (done && owner_q == OWN_DATA) begin
                d_rdata_q <= timed_out ? 32'd0 : m_rdata;
            end

            if (proto_err || timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_we      = we_q;
    assign m_size    = size_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

    assign if_stall = (if_req & ~if_gnt) | (owner_q == OWN_FETCH && state_q != ST_IDLE);
    assign d_stall  = (d_req & ~d_gnt) | (owner_q == OWN_DATA && state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT=4); grant order expectations
// follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_ready = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        if_stall, d_stall, err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .if_stall(if_stall), .d_stall(d_stall), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_stall, d_stall, m_req, m_we, err} !== 9'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, if_stall, d_stall, m_req, m_we, err}); end
        n_checks++; if (m_size !== 2'b00 || m_addr !== 32'd0 || m_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem: size %b addr %h wdata %h want 0", m_size, m_addr, m_wdata); end
        n_checks++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: if %h d %h want 0", if_rdata, d_rdata); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h0001_0000;
        @(negedge clk);
        n_checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: if_gnt %b d_gnt %b want 1 0", if_gnt, d_gnt); end
        n_checks++; if (m_req !== 1'b0 || if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: m_req %b if_stall %b want 0 0", m_req, if_stall); end
        tick();
        if_req = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h0001_0000) begin n_fail++; $display("FAIL fetch_issue: m_req %b addr %h want 1 00010000", m_req, m_addr); end
        n_checks++; if (m_we !== 1'b0 || m_size !== 2'b10) begin n_fail++; $display("FAIL fetch_attr: we %b size %b want 0 10", m_we, m_size); end
        n_checks++; if (if_gnt !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall: gnt %b stall %b want 0 1", if_gnt, if_stall); end
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (m_req !== 1'b0 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_resp: m_req %b rvalid %b want 0 0", m_req, if_rvalid); end
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0013;
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_early: rvalid %b want 0", if_rvalid); end
        tick();
        m_rvalid = 1'b0; m_rdata = 32'd0;
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_data: rvalid %b rdata %h d_rvalid %b want 1 00000013 0", if_rvalid, if_rdata, d_rvalid); end
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_unstall: stall %b want 0", if_stall); end
        tick();
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h13 || err !== 1'b0) begin n_fail++; $display("FAIL fetch_hold: rvalid %b rdata %h err %b want 0 00000013 0", if_rvalid, if_rdata, err); end
        tick();
    endtask

    task automatic test_both();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 32'h0000_3000;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL both_first: d_gnt %b if_gnt %b want 1 0", d_gnt, if_gnt); end
        n_checks++; if (if_stall !== 1'b1 || d_stall !== 1'b0) begin n_fail++; $display("FAIL both_stall0: if %b d %b want 1 0", if_stall, d_stall); end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h3000 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL both_wait: m_req %b addr %h if_gnt %b want 1 00003000 0", m_req, m_addr, if_gnt); end
        n_checks++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin n_fail++; $display("FAIL both_stall1: if %b d %b want 1 1", if_stall, d_stall); end
        tick();
        m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
        @(negedge clk);
        n_checks++; if (m_addr !== 32'h3000 || m_size !== 2'b01 || d_rvalid !== 1'b0 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL both_accept: addr %h size %b d_rvalid %b if_gnt %b want 00003000 01 0 0", m_addr, m_size, d_rvalid, if_gnt); end
        tick();
        m_ready = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_0001 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL both_dresp: d_rvalid %b rdata %h if_rvalid %b want 1 cafe0001 0", d_rvalid, d_rdata, if_rvalid); end
        n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL both_fgnt: if_gnt %b want 1", if_gnt); end
        tick();
        if_req = 1'b0; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_0055;
        @(negedge clk);
        n_checks++; if (m_addr !== 32'h400 || m_size !== 2'b10) begin n_fail++; $display("FAIL both_faddr: addr %h size %b want 00000400 10", m_addr, m_size); end
        tick();
        m_ready = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55 || d_rvalid !== 1'b0 || d_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL both_fresp: if_rvalid %b if_rdata %h d_rvalid %b d_rdata %h want 1 00000055 0 cafe0001", if_rvalid, if_rdata, d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_data;
        if_req = 1'b1; if_addr = 32'h0000_0800;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0000_4000;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_RR_EN
            exp_data = (i % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            @(negedge clk);
            n_checks++; if (d_gnt !== exp_data || if_gnt !== !exp_data) begin n_fail++; $display("FAIL b2b_gnt%0d: d_gnt %b if_gnt %b want %b %b", i, d_gnt, if_gnt, exp_data, !exp_data); end
            tick();
            m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_0077;
            @(negedge clk);
            tick();
            m_ready = 1'b0; m_rvalid = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: d_gnt %b want 1", d_gnt); end
        tick();
        d_req = 1'b0; d_wdata = 32'd0; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'd0;
        @(negedge clk);
        n_checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h2000 || m_size !== 2'b10) begin n_fail++; $display("FAIL wr_issue: req %b we %b wdata %h addr %h size %b want 1 1 deadbeef 00002000 10", m_req, m_we, m_wdata, m_addr, m_size); end
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_early: d_rvalid %b want 0", d_rvalid); end
        tick();
        m_ready = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1 || m_req !== 1'b0 || m_size !== 2'b10 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL wr_done: d_rvalid %b m_req %b size %b d_rdata %h want 1 0 10 00000000", d_rvalid, m_req, m_size, d_rdata); end
        n_checks++; if (err !== 1'b0 || d_stall !== 1'b0) begin n_fail++; $display("FAIL wr_err: err %b d_stall %b want 0 0", err, d_stall); end
        tick();
    endtask

    task automatic test_timeout();
        if_req = 1'b1; if_addr = 32'h0000_0500;
        @(negedge clk);
        n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL to_gnt: if_gnt %b want 1", if_gnt); end
        tick();
        if_req = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++; if (if_rvalid !== 1'b0 || err !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d: rvalid %b err %b stall %b want 0 0 1", k, if_rvalid, err, if_stall); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'd0 || err !== 1'b1) begin n_fail++; $display("FAIL to_fire: rvalid %b rdata %h err %b want 1 00000000 1", if_rvalid, if_rdata, err); end
        tick();
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b0 || m_req !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL to_after: rvalid %b m_req %b err %b want 0 0 1", if_rvalid, m_req, err); end
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: err %b want 1", err); end
        tick();
    endtask

    task automatic test_reset_in_resp();
        if_req = 1'b1; if_addr = 32'h0000_0600;
        @(negedge clk);
        tick();
        if_req = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_stall, d_stall, m_req, m_we, err} !== 9'b0) begin n_fail++; $display("FAIL rir_ctrl: got %b want 000000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, if_stall, d_stall, m_req, m_we, err}); end
        n_checks++; if (m_addr !== 32'd0 || m_size !== 2'b00 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL rir_data: addr %h size %b if_rdata %h d_rdata %h want 0", m_addr, m_size, if_rdata, d_rdata); end
        tick();
        reset = 1'b0;
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0099;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rir_pre: err %b want 0", err); end
        tick();
        m_rvalid = 1'b0; m_rdata = 32'd0;
        @(negedge clk);
        n_checks++; if (err !== 1'b1 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'd0) begin n_fail++; $display("FAIL rir_stray: err %b if_rvalid %b d_rvalid %b if_rdata %h want 1 0 0 00000000", err, if_rvalid, d_rvalid, if_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_back_to_back();
        test_write();
        test_timeout();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
